btn_led_ctrl: RTL

// - Sequences board LED led0_b from push-button btn_0: synchronises and debounces the button,
//   and steps a mode FSM on each press (OFF -> ON -> SLOW -> FAST -> DIM -> OFF).
// - Generates blink timing and a PWM dim level for the LED.
// - Replaces a direct button-to-LED wire; sits at board top between the pin and the LED pin.

---
 rtl/btn_led_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 58 +++++
 rtl/btn_led_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/btn_led_pkg.sv
// Shared types and helpers for the button-driven LED sequencer.
package btn_led_pkg;

   // LED operating modes, stepped once per debounced button press.
   typedef enum logic [2:0] {
      OFF  = 3'd0,
      ON   = 3'd1,
      SLOW = 3'd2,
      FAST = 3'd3,
      DIM  = 3'd4
   } mode_t;

   // Mode sequence OFF -> ON -> SLOW -> FAST -> DIM -> OFF; unknown codes recover to OFF.
   function automatic mode_t next_mode(input mode_t cur);
      case (cur)
         OFF:     next_mode = ON;
         ON:      next_mode = SLOW;
         SLOW:    next_mode = FAST;
         FAST:    next_mode = DIM;
         DIM:     next_mode = OFF;
         default: next_mode = OFF;
      endcase
   endfunction

   // True for the modes that blink from the phase counter.
   function automatic logic is_blink(input mode_t cur);
      is_blink = (cur == SLOW) || (cur == FAST);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for a raw push-button.
// rise is a registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_db,
   output logic rise
);

   localparam int unsigned    CW       = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync_1;
   logic          btn_s;
   logic          btn_db_q;
   logic [CW-1:0] cnt;

   // Bring the asynchronous button into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b0;
         btn_s  <= 1'b0;
      end else begin
         sync_1 <= btn_raw;
         btn_s  <= sync_1;
      end
   end

   // Count consecutive cycles of disagreement; accept the new level only after DEB_CYCLES of them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         btn_db <= 1'b0;
      end else if (btn_s == btn_db) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         btn_db <= btn_s;
         cnt    <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Registered rising-edge detect of the debounced level; releases produce nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_db_q <= 1'b0;
         rise     <= 1'b0;
      end else begin
         btn_db_q <= btn_db;
         rise     <= btn_db & ~btn_db_q;
      end
   end

endmodule

// File: rtl/btn_led_ctrl.sv
// Board-level LED sequencer: debounced button steps a mode FSM that selects
// off, on, slow blink, fast blink or PWM-dimmed drive for led0_b.
module btn_led_ctrl
   import btn_led_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 1_000_000,
   parameter int unsigned SLOW_HALF  = 50_000_000,
   parameter int unsigned FAST_HALF  = 12_500_000,
   parameter int unsigned PWM_W      = 8,
   parameter int unsigned DIM_DUTY   = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_0,
   output logic       led0_b,
   output logic [2:0] mode,
   output logic       press
);

   localparam int unsigned   HALF_MAX  = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int unsigned   BW        = (HALF_MAX > 2) ? $clog2(HALF_MAX) : 1;
   localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
   localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);
   // One bit wider than the counter so DIM_DUTY = 2**PWM_W gives a constant-on LED.
   localparam logic [PWM_W:0] DUTY     = (PWM_W + 1)'(DIM_DUTY);

   mode_t            mode_q;
   logic             press_i;
   logic             btn_db;
   logic [BW-1:0]    blink_cnt;
   logic [BW-1:0]    blink_last;
   logic             phase;
   logic [PWM_W-1:0] pwm_cnt;
   logic             pwm_on;
   logic             led_nxt;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_0),
      .btn_db  (btn_db),
      .rise    (press_i)
   );

   // A press pulse is only ever issued while the debounced level is high.
   assert property (@(posedge clk) disable iff (rst) press_i |-> btn_db);

   // Mode FSM: every press advances exactly one step, wrapping DIM back to OFF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= OFF;
      end else if (press_i) begin
         mode_q <= next_mode(mode_q);
      end
   end

   // Pick the half-period terminal count for the current blink rate.
   always_comb begin
      blink_last = FAST_LAST;
      if (mode_q == SLOW) begin
         blink_last = SLOW_LAST;
      end
   end

   // Blink phase: restart lit on every mode change, toggle each half-period while blinking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (press_i) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (is_blink(mode_q)) begin
         if (blink_cnt == blink_last) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end else begin
         blink_cnt <= '0;
      end
   end

   // Free-running PWM counter, independent of mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
   end

   assign pwm_on = ({1'b0, pwm_cnt} < DUTY);

   // Select the LED level for the current mode.
   always_comb begin
      led_nxt = 1'b0;
      case (mode_q)
         OFF:        led_nxt = 1'b0;
         ON:         led_nxt = 1'b1;
         SLOW, FAST: led_nxt = phase;
         DIM:        led_nxt = pwm_on;
         default:    led_nxt = 1'b0;
      endcase
   end

   // Register the LED drive so the pin is glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led0_b <= 1'b0;
      end else begin
         led0_b <= led_nxt;
      end
   end

   assign mode  = mode_q;
   assign press = press_i;

endmodule
